// File: rtl/banco_registradores_pkg.sv
// Shared constants for the register file, decode stage and forwarding unit.
package banco_registradores_pkg;

  // Data word width in bits
  localparam int LARGURA  = 32;
  // Number of architectural registers (power of 2)
  localparam int NUM_REG  = 32;
  // Register address width, log2(NUM_REG)
  localparam int LARG_END = 5;

  // Hardwired-zero register index
  localparam logic [LARG_END-1:0] REG_ZERO = '0;

endpackage

// File: rtl/banco_registradores_porta_leitura_bypass.sv
// One combinational read port: reset forcing, r0 hardwiring and write-through bypass.
module porta_leitura_bypass
  import banco_registradores_pkg::*;
(
  input  logic                reset,
  input  logic [LARG_END-1:0] endereco,
  input  logic                escrita_hab,
  input  logic [LARG_END-1:0] endereco_escrita,
  input  logic [LARGURA-1:0]  dado_escrita,
  input  logic [LARGURA-1:0]  dado_armazenado,
  output logic [LARGURA-1:0]  dado
);

  // Priority select: reset, then r0, then same-cycle write, then storage
  always_comb begin
    dado = dado_armazenado;
    if (reset) begin
      dado = '0;
    end else if (endereco == REG_ZERO) begin
      dado = '0;
    end else if (escrita_hab && (endereco == endereco_escrita)) begin
      dado = dado_escrita;
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// Register file with two asynchronous read ports and write-through bypass.
module banco_registradores
  import banco_registradores_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                escrita_hab,
  input  logic [LARG_END-1:0] endereco_escrita,
  input  logic [LARGURA-1:0]  dado_escrita,
  input  logic [LARG_END-1:0] endereco_leitura1,
  input  logic [LARG_END-1:0] endereco_leitura2,
  output logic [LARGURA-1:0]  dado_leitura1,
  output logic [LARGURA-1:0]  dado_leitura2
);

  logic [LARGURA-1:0] registradores [NUM_REG];

  // Storage update: reset clears everything and drops any concurrent write; r0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) begin
        registradores[i] <= '0;
      end
    end else if (escrita_hab && (endereco_escrita != REG_ZERO)) begin
      registradores[endereco_escrita] <= dado_escrita;
    end
  end

  porta_leitura_bypass u_porta1 (
    .reset            (reset),
    .endereco         (endereco_leitura1),
    .escrita_hab      (escrita_hab),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita),
    .dado_armazenado  (registradores[endereco_leitura1]),
    .dado             (dado_leitura1)
  );

  porta_leitura_bypass u_porta2 (
    .reset            (reset),
    .endereco         (endereco_leitura2),
    .escrita_hab      (escrita_hab),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita),
    .dado_armazenado  (registradores[endereco_leitura2]),
    .dado             (dado_leitura2)
  );

endmodule

// File: doc/banco_registradores.md
# banco_registradores

General-purpose register file for the 32-bit pipelined processor; it is the write-back stage's consumer. The stage's 2:1 result mux drives `dado_escrita`, and the MEM/WB control bits drive `escrita_hab` and `endereco_escrita`. The block provides two asynchronous read ports to the decode stage. It also provides a same-cycle write-through bypass, so decode never reads a stale value while write-back is committing the same register.

## Interface

- `LARGURA`, 32: data word width in bits.
- `NUM_REG`, 32: number of architectural registers; must be a power of 2.
- `LARG_END`, 5: address width; must equal log2(`NUM_REG`).

Ports:

- `clock`, input, 1: single clock. All state updates happen on the rising edge.
- `reset`, input, 1: synchronous, active-high. It is sampled on the rising edge of `clock`.
- `escrita_hab`, input, 1: write enable (RegWrite from MEM/WB).
- `endereco_escrita`, input, `LARG_END`: destination register.
- `dado_escrita`, input, `LARGURA`: write-back value (the WB mux output).
- `endereco_leitura1`, input, `LARG_END`: read port 1 address (rs).
- `endereco_leitura2`, input, `LARG_END`: read port 2 address (rt).
- `dado_leitura1`, output, `LARGURA`: read port 1 data.
- `dado_leitura2`, output, `LARGURA`: read port 2 data.

## Operation

- Storage is `NUM_REG` words of `LARGURA` bits.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including when bypass conditions would otherwise match.
- Write: on a rising edge with `reset`=0, `escrita_hab`=1 and `endereco_escrita`≠0, the register at `endereco_escrita` takes `dado_escrita`.
- Read, per port, is combinational, evaluated in this priority order:
  1. `reset`=1 → 0.
  2. Address = 0 → 0.
  3. `escrita_hab`=1 and read address = `endereco_escrita` → `dado_escrita` (bypass).
  4. Otherwise → stored word.
- Both ports are independent. Both may address the same register, and both may bypass in the same cycle.
- Reset: on a rising edge with `reset`=1, every register clears to 0. A write presented in that cycle is dropped.
- Reset mid-operation:
  - The array is cleared at that edge.
  - Outputs read 0 for as long as `reset` is high.
  - After `reset` deasserts, reads return 0 until new writes occur.
- No X propagation: every output is fully defined for every input combination once the first reset has been applied.

## Timing

- Write latency: 1 edge. A value presented in cycle N is stored at the end of cycle N.
- Read latency: 0 cycles, combinational from the address.
- Bypass makes a value written in cycle N visible on the read ports during cycle N. This eliminates the WB→ID hazard without a half-cycle clock.
- Output reset value: `dado_leitura1` = `dado_leitura2` = 0 while `reset`=1.
- Combinational path: `dado_escrita` → `dado_leitura*`, through a 1-deep compare-and-select. This path must close timing together with the WB mux in the same cycle.
- A write to address R followed by a write to R on the next edge: the last write wins, and the bypass shows the newer value.

## Structure

- Shared package: `LARGURA`, `NUM_REG`, `LARG_END`, and the constant `REG_ZERO` = 0, reused by the decode stage and the forwarding unit.
- One sub-module is natural: `porta_leitura_bypass`. It contains the per-port zero check, the address compare, and the bypass select, and is instantiated twice.
- The top level holds the storage array, the write logic and the reset clear.

## Test plan

- Reset, then read all addresses 0–31 on both ports → every read returns 0x00000000.
- Write 0xDEADBEEF to r5 with `escrita_hab`=1:
  - During the same cycle, `endereco_leitura1`=5 → 0xDEADBEEF via bypass.
  - Next cycle, with `escrita_hab`=0 → 0xDEADBEEF from storage.
- Write 0xFFFFFFFF to r0 → reads of r0 return 0 in both the same cycle and the next cycle.
- Write 0x11111111 to r7, then 0x22222222 to r7 on consecutive edges, with both ports addressing r7 → 0x11111111 then 0x22222222, and thereafter 0x22222222.
- Write 0x12345678 to r3 with `escrita_hab`=0 → r3 still reads 0; port 2 reading r4 is unaffected by port 1 activity.
- Fill r1–r31 with value = address × 0x01010101, then assert `reset` for one cycle with a concurrent write of 0xAAAAAAAA to r9 → all reads 0 during reset and after; r9 = 0.
